grey_window_gen: RTL and testbench
==================================

GREY_WINDOW_GEN -- requirements
Module: grey_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512: pixels per line, range 4..4096.
REQ-002 SHALL have parameter IMG_HEIGHT, default 512: lines per frame, range 3..4096.
REQ-003 SHALL have port axi_clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port axi_reset_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_grey_data_valid  input  1: upstream greyscale pixel valid.
REQ-006 SHALL have port i_grey_data  input  8: greyscale pixel, raster order.
REQ-007 SHALL have port o_grey_data_ready  output  1: block can accept a pixel.
REQ-008 SHALL have port o_window_valid  output  1: o_window holds a valid 3x3 window.
REQ-009 SHALL have port o_window  output  72: window; pixel (i,j) at bits [8*(3i+j)+7 : 8*(3i+j)]; i=0 oldest row, j=0 oldest column.
REQ-010 SHALL have port i_window_ready  input  1: downstream accepts the window.
REQ-011 SHALL have port o_window_last  output  1: marks the final window of a frame (see Configuration).

Function
REQ-012 SHALL accept a pixel on a cycle where i_grey_data_valid & o_grey_data_ready; no other state advances on input.
REQ-013 SHALL drive o_grey_data_ready = i_window_ready | ~o_window_valid (single output register, no skid buffer).
REQ-014 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advanced per accepted pixel; col wraps to 0 and increments row; at row=IMG_HEIGHT-1, col=IMG_WIDTH-1 both wrap to 0 (next frame).
REQ-015 SHALL hold two line buffers of IMG_WIDTH x 8 bits addressed by col: on accept, read both at col, write line1 data into line0 and the new pixel into line1 (line0 = row-2, line1 = row-1).
REQ-016 SHALL hold a 3x3 shift register; on accept shift columns left and load new column {line0[col], line1[col], pixel} as j=2 of rows i=0,1,2.
REQ-017 SHALL produce a window only for accepted pixels with row>=2 and col>=2; no border padding; (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
REQ-018 SHALL register o_window/o_window_valid with latency 1 cycle from the producing accept.
REQ-019 SHALL clear o_window_valid when i_window_ready is high and no new window is produced that cycle; o_window SHALL be stable while o_window_valid & ~i_window_ready.
REQ-020 SHALL ignore i_grey_data when not accepted; window contents SHALL never mix pixels across a line wrap (column history for col<2 is discarded from output).

Reset
REQ-021 SHALL on axi_reset_n low asynchronously clear col, row, shift register, o_window (0), o_window_valid (0), o_window_last (0).
REQ-022 Line buffer contents SHALL NOT require reset; windows after reset SHALL use only pixels accepted after reset release.
REQ-023 Reset mid-frame SHALL discard the partial frame; first post-reset pixel is treated as row 0, col 0.

Configuration
REQ-024 Macro GREY_WINDOW_LAST_EN SHALL, when defined, drive o_window_last high together with o_window_valid for the window produced at row=IMG_HEIGHT-1, col=IMG_WIDTH-1, held with the window under backpressure.
REQ-025 Without GREY_WINDOW_LAST_EN, o_window_last SHALL be constant 0; all other behaviour identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 16*row+col)
REQ-026 Ramp frame, i_window_ready=1 -> exactly 4 windows; first one cycle after 11th accept, o_window bytes j/i order = 00,01,02,10,11,12,20,21,22 (LSB first); last = 11,12,13,21,22,23,31,32,33.
REQ-027 i_window_ready=0 for 5 cycles after first window -> o_grey_data_ready=0, o_window held unchanged, no pixel accepted, resume yields identical window sequence.
REQ-028 Two back-to-back frames -> 8 windows, second frame window 1 equal to first frame window 1.
REQ-029 Reset asserted after 9 pixels, then full frame -> no window before 11th post-reset pixel; windows match REQ-026.
REQ-030 GREY_WINDOW_LAST_EN defined -> o_window_last=1 only with window 11,...,33; undefined -> o_window_last=0 throughout.
REQ-031 Random i_grey_data_valid gaps (50%) -> window sequence identical to REQ-026.

Source files
------------

// File: rtl/grey_window_gen.sv
// grey_window_gen: streams raster greyscale pixels into 3x3 windows via two line buffers.
// Define GREY_WINDOW_LAST_EN to flag the final window of each frame on o_window_last.
module grey_window_gen #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic        axi_clk,
   input  logic        axi_reset_n,
   input  logic        i_grey_data_valid,
   input  logic [7:0]  i_grey_data,
   output logic        o_grey_data_ready,
   output logic        o_window_valid,
   output logic [71:0] o_window,
   input  logic        i_window_ready,
   output logic        o_window_last
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    line0 [IMG_WIDTH];
   logic [7:0]    line1 [IMG_WIDTH];
   logic [7:0]    win [3][3];
   logic [7:0]    col_in [3];
   logic [71:0]   nxt_win;
   logic          accept, col_end, row_end, produce;
   assign o_grey_data_ready = i_window_ready | ~o_window_valid;
   assign accept  = i_grey_data_valid & o_grey_data_ready;
   assign col_end = col == CW'(IMG_WIDTH - 1);
   assign row_end = row == RW'(IMG_HEIGHT - 1);
   // Columns 0/1 still hold the previous line's tail, so they never form a window
   assign produce = accept & (row >= RW'(2)) & (col >= CW'(2));
   always_comb begin
      col_in[0] = line0[col];
      col_in[1] = line1[col];
      col_in[2] = i_grey_data;
      for (int i = 0; i < 3; i++) begin
         nxt_win[8*(3*i)   +: 8] = win[i][1];
         nxt_win[8*(3*i+1) +: 8] = win[i][2];
         nxt_win[8*(3*i+2) +: 8] = col_in[i];
      end
   end
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= col_end ? '0 : col + 1'b1;
         row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
      end
   end
   always_ff @(posedge axi_clk) begin
      if (accept) begin
         line0[col] <= line1[col];
         line1[col] <= i_grey_data;
      end
   end
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win[i][j] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
            win[i][2] <= col_in[i];
         end
      end
   end
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         o_window       <= '0;
         o_window_valid <= 1'b0;
      end else if (produce) begin
         o_window       <= nxt_win;
         o_window_valid <= 1'b1;
      end else if (i_window_ready) begin
         o_window_valid <= 1'b0;
      end
   end
`ifdef GREY_WINDOW_LAST_EN
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n)
         o_window_last <= 1'b0;
      else if (produce)
         o_window_last <= row_end & col_end;
      else if (i_window_ready)
         o_window_last <= 1'b0;
   end
`else
   assign o_window_last = 1'b0;
`endif
endmodule

// File: tb/tb_grey_window_gen.sv
// tb_grey_window_gen: directed table-driven bench for grey_window_gen on a 4x4 ramp frame.
module tb_grey_window_gen;
`ifdef GREY_WINDOW_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif
   typedef struct {
      logic [7:0]  pix;
      logic        prod;
      logic [71:0] win;
      logic        last;
   } vec_t;
   vec_t        vec [16];
   logic        axi_clk = 1'b0;
   logic        axi_reset_n = 1'b0;
   logic        i_grey_data_valid = 1'b0;
   logic [7:0]  i_grey_data = 8'h00;
   logic        i_window_ready = 1'b1;
   logic        o_grey_data_ready, o_window_valid, o_window_last;
   logic [71:0] o_window;
   int          checks = 0;
   int          fails = 0;
   logic [72:0] got [$];
   logic        hold_prev = 1'b0;
   logic [71:0] win_prev = '0;

   always #5 axi_clk = ~axi_clk;

   grey_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .axi_clk(axi_clk),
      .axi_reset_n(axi_reset_n),
      .i_grey_data_valid(i_grey_data_valid),
      .i_grey_data(i_grey_data),
      .o_grey_data_ready(o_grey_data_ready),
      .o_window_valid(o_window_valid),
      .o_window(o_window),
      .i_window_ready(i_window_ready),
      .o_window_last(o_window_last)
   );

   task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Collects every window handed downstream and checks stability under backpressure
   always @(negedge axi_clk) begin
      if (axi_reset_n) begin
         if (hold_prev) begin
            check("hold_valid", 73'(o_window_valid), 73'(1));
            check("hold_window", 73'(o_window), 73'(win_prev));
         end
         check("last_without_valid", 73'(o_window_last & ~o_window_valid), 73'(0));
         if (o_window_valid && i_window_ready) got.push_back({o_window_last, o_window});
         hold_prev = o_window_valid & ~i_window_ready;
         win_prev  = o_window;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic send_pixel(input logic [7:0] p, input bit gaps);
      int   n = 0;
      logic acc = 1'b0;
      if (gaps)
         while ($urandom_range(1, 0) == 1) begin
            i_grey_data = 8'($urandom);
            @(posedge axi_clk); #1;
         end
      i_grey_data_valid = 1'b1;
      i_grey_data = p;
      do begin
         @(negedge axi_clk);
         acc = o_grey_data_ready;
         @(posedge axi_clk); #1;
         n++;
      end while (!acc && n < 200);
      check("accept", 73'(acc), 73'(1));
      i_grey_data_valid = 1'b0;
      i_grey_data = 8'($urandom);
   endtask

   task automatic run_frame(input bit gaps);
      for (int i = 0; i < 16; i++) begin
         send_pixel(vec[i].pix, gaps);
         check($sformatf("valid_after_px%0d", i), 73'(o_window_valid), 73'(vec[i].prod));
         check($sformatf("last_after_px%0d", i), 73'(o_window_last), 73'(vec[i].last));
         if (vec[i].prod) check($sformatf("window_after_px%0d", i), 73'(o_window), 73'(vec[i].win));
      end
   endtask

   task automatic check_windows(input int nf, input string tag);
      logic [72:0] exp_q [$];
      repeat (2) @(posedge axi_clk);
      #1;
      for (int f = 0; f < nf; f++)
         for (int i = 0; i < 16; i++)
            if (vec[i].prod) exp_q.push_back({vec[i].last, vec[i].win});
      check({tag, "_count"}, 73'(got.size()), 73'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         check($sformatf("%s_win%0d", tag, k), got[k], exp_q[k]);
      got.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         vec[i].pix  = 8'(16 * (i / 4) + i % 4);
         vec[i].prod = 1'b0;
         vec[i].win  = '0;
         vec[i].last = 1'b0;
      end
      vec[10].prod = 1'b1; vec[10].win = 72'h22_21_20_12_11_10_02_01_00;
      vec[11].prod = 1'b1; vec[11].win = 72'h23_22_21_13_12_11_03_02_01;
      vec[14].prod = 1'b1; vec[14].win = 72'h32_31_30_22_21_20_12_11_10;
      vec[15].prod = 1'b1; vec[15].win = 72'h33_32_31_23_22_21_13_12_11;
      vec[15].last = LAST_EN;

      repeat (2) @(posedge axi_clk);
      #1;
      check("rst_valid", 73'(o_window_valid), 73'(0));
      check("rst_window", 73'(o_window), 73'(0));
      check("rst_last", 73'(o_window_last), 73'(0));
      check("rst_ready", 73'(o_grey_data_ready), 73'(1));
      axi_reset_n = 1'b1;

      run_frame(1'b0);
      check_windows(1, "ramp");

      for (int i = 0; i < 11; i++) send_pixel(vec[i].pix, 1'b0);
      check("bp_first_valid", 73'(o_window_valid), 73'(1));
      i_window_ready = 1'b0;
      i_grey_data_valid = 1'b1;
      i_grey_data = vec[11].pix;
      repeat (5) begin
         @(negedge axi_clk);
         check("bp_ready_low", 73'(o_grey_data_ready), 73'(0));
         check("bp_window_held", 73'(o_window), 73'(vec[10].win));
         @(posedge axi_clk); #1;
      end
      i_window_ready = 1'b1;
      for (int i = 11; i < 16; i++) send_pixel(vec[i].pix, 1'b0);
      check_windows(1, "bp");

      run_frame(1'b0);
      run_frame(1'b0);
      check_windows(2, "two_frames");

      for (int i = 0; i < 11; i++) send_pixel(vec[i].pix, 1'b0);
      check("async_pre_valid", 73'(o_window_valid), 73'(1));
      #2 axi_reset_n = 1'b0;
      #1;
      check("async_valid", 73'(o_window_valid), 73'(0));
      check("async_window", 73'(o_window), 73'(0));
      check("async_last", 73'(o_window_last), 73'(0));
      @(posedge axi_clk); #1;
      axi_reset_n = 1'b1;
      got.delete();

      for (int i = 0; i < 9; i++) send_pixel(vec[i].pix, 1'b0);
      axi_reset_n = 1'b0;
      @(posedge axi_clk); #1;
      axi_reset_n = 1'b1;
      check("partial_no_window", 73'(got.size()), 73'(0));
      run_frame(1'b0);
      check_windows(1, "after_reset");

      run_frame(1'b1);
      check_windows(1, "gaps");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
